// File: rtl/riscv_pkg.sv
// Shared core-wide constants: register file geometry and the hardwired zero register index.
package riscv_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

endpackage

// File: rtl/reg_file.sv
// Integer register file: 2**ADDR_W x DATA_W flops, one synchronous write port,
// two combinational read ports, and register 0 reading as zero.
module reg_file
    import riscv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int                NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];

    // Reset wins over a same-edge write; writes to the zero register are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != ZERO_A)) begin
            regs[wa] <= wd;
        end
    end

    // Masking at the read mux keeps x0 at zero even before the first reset.
    assign rd1 = (ra1 == ZERO_A) ? '0 : regs[ra1];
    assign rd2 = (ra2 == ZERO_A) ? '0 : regs[ra2];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a vector table plus hand-written sweep/reset
// sequences, with expected read data queued and popped at each compare point.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb_q[$];
    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl[16];

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        total++;
        if (rd1 !== e[63:32]) begin
            bad++;
            $display("FAIL %s rd1 got=%h want=%h (ra1=%0d)", name, rd1, e[63:32], ra1);
        end
        total++;
        if (rd2 !== e[31:0]) begin
            bad++;
            $display("FAIL %s rd2 got=%h want=%h (ra2=%0d)", name, rd2, e[31:0], ra2);
        end
    endtask

    // Drive one cycle: reads are checked just before the edge (old contents),
    // then the edge is taken and the reference array is updated.
    task automatic step(input string name, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] e1, input logic [31:0] e2);
        we  = w;
        wa  = a;
        wd  = d;
        ra1 = r1;
        ra2 = r2;
        sb_q.push_back({e1, e2});
        #1;
        compare(name);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (w && a != 5'd0) begin
            model[a] = d;
        end
        #1;
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            sb_q.push_back({model[i], model[31 - i]});
            #1;
            compare(name);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd1, 32'd1,          5'd1, 5'd0, 32'd0, 32'd0};
        tbl[1]  = '{1'b1, 5'd2, 32'd2,          5'd1, 5'd2, 32'd1, 32'd0};
        tbl[2]  = '{1'b1, 5'd3, 32'd3,          5'd2, 5'd3, 32'd2, 32'd0};
        tbl[3]  = '{1'b0, 5'd0, 32'd0,          5'd2, 5'd3, 32'd2, 32'd3};
        tbl[4]  = '{1'b0, 5'd0, 32'd0,          5'd0, 5'd1, 32'd0, 32'd1};
        tbl[5]  = '{1'b1, 5'd0, 32'hDEADBEEF,   5'd0, 5'd0, 32'd0, 32'd0};
        tbl[6]  = '{1'b0, 5'd0, 32'd0,          5'd0, 5'd0, 32'd0, 32'd0};
        tbl[7]  = '{1'b0, 5'd5, 32'h1234,       5'd5, 5'd5, 32'd0, 32'd0};
        tbl[8]  = '{1'b0, 5'd5, 32'h1234,       5'd5, 5'd5, 32'd0, 32'd0};
        tbl[9]  = '{1'b0, 5'd5, 32'h1234,       5'd5, 5'd3, 32'd0, 32'd3};
        tbl[10] = '{1'b1, 5'd7, 32'hA5A5A5A5,   5'd7, 5'd7, 32'd0, 32'd0};
        tbl[11] = '{1'b0, 5'd0, 32'd0,          5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[12] = '{1'b1, 5'd9, 32'h11,         5'd9, 5'd0, 32'd0, 32'd0};
        tbl[13] = '{1'b1, 5'd9, 32'h22,         5'd9, 5'd1, 32'h11, 32'd1};
        tbl[14] = '{1'b1, 5'd10, 32'h33,        5'd9, 5'd10, 32'h22, 32'd0};
        tbl[15] = '{1'b0, 5'd0, 32'd0,          5'd10, 5'd9, 32'h33, 32'h22};

        for (int i = 0; i < 32; i++) model[i] = '0;
        rst_n = 1'b0;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        ra1   = '0;
        ra2   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        sweep("reset_sweep");

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd,
                 tbl[i].ra1, tbl[i].ra2, tbl[i].e1, tbl[i].e2);
        end

        // Fill every register with its own index, then read all of them back.
        for (int i = 1; i < 32; i++) begin
            step("fill", 1'b1, 5'(i), 32'(i), 5'(i), 5'd0, model[i], 32'd0);
        end
        sweep("index_sweep");
        for (int i = 0; i < 32; i++) begin
            total++;
            if (model[i] !== 32'(i)) begin
                bad++;
                $display("FAIL model_index x%0d got=%h want=%h", i, model[i], i);
            end
        end

        // Reset with a colliding write: reads stay live until the edge, then all zero.
        rst_n = 1'b0;
        step("reset_pre_edge", 1'b1, 5'd4, 32'd9, 5'd4, 5'd31, 32'd4, 32'd31);
        rst_n = 1'b1;
        we    = 1'b0;
        sweep("post_reset_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
